// File: rtl/varredura_matriz_pkg.sv
// Shared types and constants for the 5x7 LED matrix scanner.
// Row and column lines are active-low throughout.
package varredura_matriz_pkg;

    localparam int NUM_COLUNAS = 5;
    localparam int NUM_LINHAS  = 7;

    localparam logic [NUM_LINHAS-1:0]  LINHAS_APAGADAS  = 7'b1111111;
    localparam logic [NUM_COLUNAS-1:0] COLUNAS_APAGADAS = 5'b11111;

    typedef enum logic [1:0] {
        DESLIGADO,
        APAGAR,
        EXIBIR
    } estado_t;

    // Element 0 holds column 1.
    typedef logic [NUM_COLUNAS-1:0][NUM_LINHAS-1:0] quadro_t;

    // One-hot active-low enable for a 1-based column index.
    function automatic logic [NUM_COLUNAS-1:0] habilita_coluna(
        input logic [2:0] col
    );
        logic [NUM_COLUNAS-1:0] s;
        s = COLUNAS_APAGADAS;
        case (col)
            3'd1:    s = 5'b11110;
            3'd2:    s = 5'b11101;
            3'd3:    s = 5'b11011;
            3'd4:    s = 5'b10111;
            3'd5:    s = 5'b01111;
            default: s = COLUNAS_APAGADAS;
        endcase
        return s;
    endfunction

    // Row vector of a 1-based column; dark for an idle index.
    function automatic logic [NUM_LINHAS-1:0] linhas_da_coluna(
        input quadro_t    q,
        input logic [2:0] col
    );
        logic [NUM_LINHAS-1:0] l;
        l = LINHAS_APAGADAS;
        case (col)
            3'd1:    l = q[0];
            3'd2:    l = q[1];
            3'd3:    l = q[2];
            3'd4:    l = q[3];
            3'd5:    l = q[4];
            default: l = LINHAS_APAGADAS;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/varredura_matriz_divisor_varredura.sv
// Slot timer: counts 0..DIVISOR-1 and flags the last cycle.
// A synchronous clear holds it at zero while the scan is idle.
module divisor_varredura #(
    parameter int DIVISOR = 50000,
    parameter int CW      = $clog2(DIVISOR)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          limpar_i,
    output logic [CW-1:0] cnt_o,
    output logic          fim_slot_o
);

    localparam logic [CW-1:0] ULTIMO = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_o      = cnt_q;
    assign fim_slot_o = (cnt_q == ULTIMO);

    // Next count: clear, wrap at slot end, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (limpar_i || fim_slot_o) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/varredura_matriz.sv
// Column-multiplexed driver for a 5x7 active-low LED matrix.
// Frames are snapshotted whole so one frame never mixes states.
module varredura_matriz #(
    parameter int DIVISOR = 50000,
    parameter int BLANK   = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ligado,
    input  logic [6:0] coluna1,
    input  logic [6:0] coluna2,
    input  logic [6:0] coluna3,
    input  logic [6:0] coluna4,
    input  logic [6:0] coluna5,
    output logic [4:0] sel_coluna,
    output logic [6:0] linhas,
    output logic [2:0] coluna_ativa,
    output logic       fim_quadro
);

    import varredura_matriz_pkg::*;

    localparam int CW = $clog2(DIVISOR);

    localparam logic [CW-1:0] ULT_APAGAR =
        CW'((BLANK > 0) ? BLANK - 1 : 0);

    // With no blanking a slot opens straight into the lit phase.
    localparam estado_t INICIO_SLOT =
        (BLANK == 0) ? EXIBIR : APAGAR;

    localparam logic [2:0] ULT_COL = 3'(NUM_COLUNAS);

    estado_t       estado_q, estado_d;
    logic [2:0]    col_q, col_d;
    quadro_t       quadro_q, quadro_d;
    logic          fim_q, fim_d;
    logic [4:0]    sel_q, sel_d;
    logic [6:0]    lin_q, lin_d;
    logic [CW-1:0] cnt;
    logic          fim_slot;
    logic          limpar;
    quadro_t       entrada;

    assign entrada = {coluna5, coluna4, coluna3, coluna2, coluna1};

    // Timer is held at zero while idle so enabling starts a slot at 0.
    assign limpar = !ligado || (estado_q == DESLIGADO);

    divisor_varredura #(
        .DIVISOR (DIVISOR),
        .CW      (CW)
    ) u_divisor (
        .clock      (clock),
        .reset_n    (reset_n),
        .limpar_i   (limpar),
        .cnt_o      (cnt),
        .fim_slot_o (fim_slot)
    );

    // Scan sequencing: state, column index, snapshot and frame pulse.
    always_comb begin
        estado_d = estado_q;
        col_d    = col_q;
        quadro_d = quadro_q;
        fim_d    = 1'b0;
        if (!ligado) begin
            estado_d = DESLIGADO;
            col_d    = 3'd0;
        end else begin
            unique case (estado_q)
                DESLIGADO: begin
                    quadro_d = entrada;
                    col_d    = 3'd1;
                    fim_d    = 1'b1;
                    estado_d = INICIO_SLOT;
                end
                APAGAR, EXIBIR: begin
                    if (fim_slot) begin
                        estado_d = INICIO_SLOT;
                        if (col_q == ULT_COL) begin
                            col_d    = 3'd1;
                            quadro_d = entrada;
                            fim_d    = 1'b1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end else if (estado_q == APAGAR &&
                                 cnt == ULT_APAGAR) begin
                        estado_d = EXIBIR;
                    end
                end
                default: begin
                    estado_d = DESLIGADO;
                    col_d    = 3'd0;
                end
            endcase
        end
    end

    // Outputs are precomputed from next state so they leave registers.
    always_comb begin
        sel_d = COLUNAS_APAGADAS;
        lin_d = LINHAS_APAGADAS;
        if (estado_d == EXIBIR) begin
            sel_d = habilita_coluna(col_d);
            lin_d = linhas_da_coluna(quadro_d, col_d);
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= DESLIGADO;
            col_q    <= 3'd0;
            quadro_q <= '1;
            fim_q    <= 1'b0;
            sel_q    <= COLUNAS_APAGADAS;
            lin_q    <= LINHAS_APAGADAS;
        end else begin
            estado_q <= estado_d;
            col_q    <= col_d;
            quadro_q <= quadro_d;
            fim_q    <= fim_d;
            sel_q    <= sel_d;
            lin_q    <= lin_d;
        end
    end

    assign sel_coluna   = sel_q;
    assign linhas       = lin_q;
    assign coluna_ativa = col_q;
    assign fim_quadro   = fim_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// Bench for varredura_matriz: two instances (8/2 and 2/0) checked
// against a time-since-enable model of the scan.
module tb_varredura_matriz;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       ligado;
    logic [6:0] c1, c2, c3, c4, c5;

    logic [4:0] sel_a, sel_b;
    logic [6:0] lin_a, lin_b;
    logic [2:0] col_a, col_b;
    logic       fim_a, fim_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: cycles elapsed since the enabling edge, -1 when idle.
    int               t = -1;
    logic [4:0][6:0]  snap_a = '1;
    logic [4:0][6:0]  snap_b = '1;

    always #5 clock = ~clock;

    varredura_matriz #(.DIVISOR(8), .BLANK(2)) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .ligado       (ligado),
        .coluna1      (c1),
        .coluna2      (c2),
        .coluna3      (c3),
        .coluna4      (c4),
        .coluna5      (c5),
        .sel_coluna   (sel_a),
        .linhas       (lin_a),
        .coluna_ativa (col_a),
        .fim_quadro   (fim_a)
    );

    varredura_matriz #(.DIVISOR(2), .BLANK(0)) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .ligado       (ligado),
        .coluna1      (c1),
        .coluna2      (c2),
        .coluna3      (c3),
        .coluna4      (c4),
        .coluna5      (c5),
        .sel_coluna   (sel_b),
        .linhas       (lin_b),
        .coluna_ativa (col_b),
        .fim_quadro   (fim_b)
    );

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h",
                   tag, t, obs, exp);
        end
    endtask

    // Expected {sel, linhas, coluna, fim} after tt cycles of scanning.
    function automatic logic [15:0] esperado(
        int tt, int d, int b, logic [4:0][6:0] sn
    );
        logic [4:0] s;
        logic [6:0] l;
        int         pos, ci;
        if (tt < 0) return {5'h1F, 7'h7F, 3'd0, 1'b0};
        pos = tt % d;
        ci  = (tt / d) % 5;
        s   = 5'h1F;
        l   = 7'h7F;
        if (pos >= b) begin
            s[ci] = 1'b0;
            l     = sn[ci];
        end
        return {s, l, 3'(ci + 1), (tt % (5 * d)) == 0};
    endfunction

    task automatic verifica();
        logic [15:0] ea, eb;
        ea = esperado(t, 8, 2, snap_a);
        eb = esperado(t, 2, 0, snap_b);
        chk("a_sel", 8'(sel_a), 8'(ea[15:11]));
        chk("a_lin", 8'(lin_a), 8'(ea[10:4]));
        chk("a_col", 8'(col_a), 8'(ea[3:1]));
        chk("a_fim", 8'(fim_a), 8'(ea[0]));
        chk("b_sel", 8'(sel_b), 8'(eb[15:11]));
        chk("b_lin", 8'(lin_b), 8'(eb[10:4]));
        chk("b_col", 8'(col_b), 8'(eb[3:1]));
        chk("b_fim", 8'(fim_b), 8'(eb[0]));
    endtask

    // Advance model with the inputs about to be sampled, then clock.
    task automatic step();
        logic [4:0][6:0] cur;
        cur = {c5, c4, c3, c2, c1};
        if (!ligado) begin
            t = -1;
        end else begin
            t = (t < 0) ? 0 : t + 1;
            if (t % 40 == 0) snap_a = cur;
            if (t % 10 == 0) snap_b = cur;
        end
        @(posedge clock);
        #1;
        verifica();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_sel_a"}, 8'(sel_a), 8'h1F);
        chk({tag, "_lin_a"}, 8'(lin_a), 8'h7F);
        chk({tag, "_col_a"}, 8'(col_a), 8'h00);
        chk({tag, "_fim_a"}, 8'(fim_a), 8'h00);
        chk({tag, "_sel_b"}, 8'(sel_b), 8'h1F);
        chk({tag, "_lin_b"}, 8'(lin_b), 8'h7F);
    endtask

    initial begin
        bit ok;
        reset_n = 1'b0;
        ligado  = 1'b0;
        {c1, c2, c3, c4, c5} = '1;
        repeat (2) @(posedge clock);
        #1;
        chk_reset("rst0");
        reset_n = 1'b1;
        step();

        // First frame: only linha 1 of column 1 lit.
        c1     = 7'b1111110;
        ligado = 1'b1;
        repeat (10) step();

        // Column 3 changes while column 2 is scanned.
        c3 = 7'b0111111;
        repeat (190) step();

        // Drop enable at column 3, cnt 5.
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (t % 40 == 21) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $error("FAIL wait_col3 timeout");
        end
        ligado = 1'b0;
        step();
        c1     = 7'b1010101;
        ligado = 1'b1;
        repeat (20) step();

        // Random columns and occasional one-cycle disables.
        for (int i = 0; i < 600; i++) begin
            c1     = 7'($urandom);
            c2     = 7'($urandom);
            c3     = 7'($urandom);
            c4     = 7'($urandom);
            c5     = 7'($urandom);
            ligado = ($urandom_range(0, 49) != 0);
            step();
        end

        // Asynchronous reset while a column is lit.
        ligado = 1'b1;
        ok     = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (t >= 0 && t % 8 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $error("FAIL wait_exibir timeout");
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("rst_async");
        chk("rst_async_fim_b", 8'(fim_b), 8'h00);
        t      = -1;
        ligado = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();
        ligado = 1'b1;
        repeat (45) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
